bist_tpg: RTL

BIST_TPG -- requirements
Module: bist_tpg

---
 rtl/bist_tpg.sv | 101 ++++++++++
 1 files changed

// File: rtl/bist_tpg.sv
`default_nettype none
// ============================================================================
// Module   : bist_tpg
// Purpose  : LFSR-based ALU test pattern generator for built-in self test.
// Revision : 1.0 - initial release
// ============================================================================
module bist_tpg #(
    parameter logic [15:0] SEED_A        = 16'hACE1,
    parameter logic [15:0] SEED_B        = 16'h1D0F,
    parameter int unsigned PATTERN_COUNT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    output logic [15:0] pat_a,
    output logic [15:0] pat_b,
    output logic        pat_cin,
    output logic [1:0]  pat_sel,
    output logic        pat_valid,
    output logic [15:0] pat_index,
    output logic        busy,
    output logic        done
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [15:0] C_SEED_A = (SEED_A == 16'h0000) ? 16'h0001 : SEED_A;
    localparam logic [15:0] C_SEED_B = (SEED_B == 16'h0000) ? 16'h0001 : SEED_B;
    localparam logic [15:0] C_LAST   = 16'(PATTERN_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_a_q, lfsr_a_d;
    logic [15:0] lfsr_b_q, lfsr_b_d;
    logic [15:0] index_q,  index_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_a_q <= 16'h0000;
            lfsr_b_q <= 16'h0000;
            index_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            index_q  <= index_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        index_d  = index_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_a_d = C_SEED_A;
                    lfsr_b_d = C_SEED_B;
                    index_d  = 16'h0000;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Consume the presented pattern unless downstream stalls.
                if (!hold) begin
                    lfsr_a_d = lfsr_step(lfsr_a_q);
                    lfsr_b_d = lfsr_step(lfsr_b_q);
                    index_d  = index_q + 16'd1;
                    if (index_q == C_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pat_a     = lfsr_a_q;
    assign pat_b     = lfsr_b_q;
    assign pat_index = index_q;
    assign pat_sel   = index_q[1:0];
    assign pat_cin   = index_q[2];
    assign pat_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule
`default_nettype wire
